// File: rtl/byte_serial_addsub.sv
// byte_serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor for an area-reduced RV32I execute
//   stage. A single 8-bit slice computes A + (B ^ {8{sub}}) + cin one byte per
//   cycle, LSB first, with the slice carry chained through a register. When
//   the last byte is done, the full result and the branch/compare flags are
//   published and held until the next operation completes.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_valid     operand request valid        o_ready   unit accepts a request
//   i_a, i_b    operands (WIDTH bits)        i_sub     0: A+B, 1: A-B
//   o_valid     result/flags valid           i_ready   consumer takes result
//   o_result    sum/difference mod 2^WIDTH
//   o_carry     carry out of MSB (subtract: 1 = no borrow)
//   o_overflow  signed overflow
//   o_zero      result == 0
//   o_negative  result MSB
//   o_lt        signed A<B   (negative ^ overflow), for subtract
//   o_ltu       unsigned A<B (~carry), for subtract
module byte_serial_addsub #(
  parameter  int WIDTH     = 32,
  localparam int NUM_BYTES = WIDTH / 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_lt,
  output logic             o_ltu
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One pass through the 8-bit slice: {carry_out, sum[7:0]}.
  function automatic logic [8:0] slice_add(input logic [7:0] a,
                                           input logic [7:0] b_eff,
                                           input logic       cin);
    return {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
  endfunction

  // Two's-complement overflow from the MSB byte: operands share a sign and
  // the sum sign differs from it.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_eff_msb,
                                      input logic sum_msb);
    return (a_msb == b_eff_msb) && (sum_msb != a_msb);
  endfunction

  // Control / published-result state (reset)
  state_t           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic             cin_q,    cin_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             carry_q,  carry_d;
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
  logic             neg_q,    neg_d;
  logic             lt_q,     lt_d;
  logic             ltu_q,    ltu_d;

  // Operand and working datapath state (not reset: every bit is written
  // before it can reach an output)
  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH-1:0] b_q,   b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Current slice operands and result
  logic [7:0] a_byte;
  logic [7:0] b_eff_byte;
  logic [8:0] slice;

  always_comb begin
    a_byte     = a_q[int'(idx_q) * 8 +: 8];
    b_eff_byte = b_q[int'(idx_q) * 8 +: 8] ^ {8{sub_q}};
    slice      = slice_add(a_byte, b_eff_byte, cin_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    lt_d    = lt_q;
    ltu_d   = ltu_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    acc_d   = acc_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          sub_d   = i_sub;
          idx_d   = '0;
          // Subtraction is A + ~B + 1: the +1 enters as the first carry-in.
          cin_d   = i_sub;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d[int'(idx_q) * 8 +: 8] = slice[7:0];
        cin_d = slice[8];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          // Publish result and flags only on completion so the outputs keep
          // the previous operation's values while this one is in flight.
          res_d   = acc_d;
          carry_d = slice[8];
          ovf_d   = signed_ovf(a_byte[7], b_eff_byte[7], slice[7]);
          zero_d  = (acc_d == '0);
          neg_d   = slice[7];
          lt_d    = slice[7] ^ signed_ovf(a_byte[7], b_eff_byte[7], slice[7]);
          ltu_d   = ~slice[8];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
    end
  end

  always_ff @(posedge i_clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
    acc_q <= acc_d;
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_result   = res_q;
  assign o_carry    = carry_q;
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
  assign o_negative = neg_q;
  assign o_lt       = lt_q;
  assign o_ltu      = ltu_q;

endmodule

// File: tb/tb_byte_serial_addsub.sv
module tb_byte_serial_addsub;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_carry;
  logic        o_overflow;
  logic        o_zero;
  logic        o_negative;
  logic        o_lt;
  logic        o_ltu;

  byte_serial_addsub #(.WIDTH(32)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_sub      (i_sub),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_zero     (o_zero),
    .o_negative (o_negative),
    .o_lt       (o_lt),
    .o_ltu      (o_ltu)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // flags packed as {carry, overflow, zero, negative, lt, ltu}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic [5:0]  fl;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic logic [5:0] flags_now();
    return {o_carry, o_overflow, o_zero, o_negative, o_lt, o_ltu};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for o_valid. i_ready stays low, so
  // the unit is left parked in DONE for inspection.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, output int lat);
    int w;
    w = 0;
    while (!o_ready && w < 20) begin
      @(posedge i_clk); #1; w++;
    end
    i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_a = 32'hDEAD_BEEF; i_b = 32'hCAFE_F00D; i_sub = ~sub;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1; lat++;
    end
  endtask

  task automatic retire();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held_res;
    logic [5:0]  held_fl;

    vecs[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 6'b000001};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 6'b000111};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 6'b010101};
    vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 6'b110010};
    vecs[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 6'b101000};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 6'b101000};
    vecs[6]  = '{32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 6'b000001};
    vecs[7]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 6'b100000};
    vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 6'b111010};
    vecs[9]  = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 6'b010101};
    vecs[10] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 6'b000001};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_sub = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready",  32'(o_ready),    32'd1);
    chk("reset_valid",  32'(o_valid),    32'd0);
    chk("reset_result", o_result,        32'd0);
    chk("reset_flags",  32'(flags_now()), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < NV; i++) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_result", i), o_result, vecs[i].res);
      chk($sformatf("v%0d_flags", i), 32'(flags_now()), 32'(vecs[i].fl));
      retire();
      chk($sformatf("v%0d_idle_ready", i), 32'(o_ready), 32'd1);
      chk($sformatf("v%0d_idle_valid", i), 32'(o_valid), 32'd0);
      chk($sformatf("v%0d_result_hold", i), o_result, vecs[i].res);
    end

    // Backpressure: DONE holds for 10 cycles while requests are ignored.
    start_and_wait(32'h0000_0001, 32'h0000_0002, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    held_res = o_result;
    held_fl  = flags_now();
    chk("bp_result", held_res, 32'h0000_0003);
    for (int c = 0; c < 10; c++) begin
      i_valid = c[0];
      i_a = 32'h1111_0000 + 32'(c); i_b = 32'h0000_2222; i_sub = c[1];
      @(posedge i_clk); #1;
      chk($sformatf("bp%0d_valid", c), 32'(o_valid), 32'd1);
      chk($sformatf("bp%0d_ready", c), 32'(o_ready), 32'd0);
      chk($sformatf("bp%0d_result", c), o_result, held_res);
      chk($sformatf("bp%0d_flags", c), 32'(flags_now()), 32'(held_fl));
    end
    i_valid = 1'b0;
    retire();
    chk("bp_release_ready", 32'(o_ready), 32'd1);
    chk("bp_release_valid", 32'(o_valid), 32'd0);

    // Reset in the middle of RUN discards the partial operation.
    i_a = 32'hFFFF_FFFF; i_b = 32'h0000_0001; i_sub = 1'b0; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_run_ready", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("rst_mid_ready",  32'(o_ready),     32'd1);
    chk("rst_mid_valid",  32'(o_valid),     32'd0);
    chk("rst_mid_result", o_result,         32'd0);
    chk("rst_mid_flags",  32'(flags_now()), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge i_clk); #1;
      chk($sformatf("rst_no_valid%0d", c), 32'(o_valid), 32'd0);
    end
    start_and_wait(32'h0000_0003, 32'h0000_0004, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_result",  o_result, 32'h0000_0007);
    chk("post_rst_flags",   32'(flags_now()), 32'(6'b000001));
    retire();
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_serial_addsub.md
Name: byte_serial_addsub

Overview:
- Multi-cycle WIDTH-bit add/subtract unit built around one 8-bit adder slice (A + (B xor sub) + carry-in).
- Processes one byte per cycle, LSB first, chaining the carry through a register.
- Produces the full result plus branch/compare flags for the area-reduced RV32I execute stage.
- Sits between the operand-select stage (valid/ready in) and writeback/branch logic (valid/ready out).

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 and at least 8.
- NUM_BYTES, WIDTH/8, derived number of byte iterations; not overridden by users.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset, sampled on rising edge of i_clk.
- i_valid  input  1  operand request valid.
- o_ready  output  1  unit can accept an operand request.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_sub  input  1  0 = A+B, 1 = A-B (B inverted, carry-in 1).
- o_valid  output  1  result and flags valid.
- i_ready  input  1  consumer accepts result.
- o_result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- o_carry  output  1  carry out of MSB (for subtract, 1 = no borrow).
- o_overflow  output  1  signed overflow.
- o_zero  output  1  o_result == 0.
- o_negative  output  1  o_result[WIDTH-1].
- o_lt  output  1  signed A<B (o_negative xor o_overflow); meaningful only when i_sub was 1.
- o_ltu  output  1  unsigned A<B (~o_carry); meaningful only when i_sub was 1.

Behaviour:
- State machine: IDLE, RUN, DONE. Reset to IDLE.
- Reset values: o_ready=1, o_valid=0, o_result=0, all flags=0, byte index=0, carry register=0.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready: latch i_a, i_b and i_sub; set byte index=0 and carry register=i_sub; go to RUN.
- RUN:
  - o_ready=0, o_valid=0.
  - Each cycle, byte k = A[8k+7:8k] + (B[8k+7:8k] xor {8{sub}}) + carry register. Write the sum into result byte k, store the slice carry-out, increment k.
  - After byte NUM_BYTES-1 is written, go to DONE.
  - Overflow is computed from the last byte: (A_msb == Beff_msb) && (sum_msb != A_msb).
- DONE:
  - o_valid=1, o_ready=0; result and flags are held stable.
  - On i_valid... no: on o_valid&i_ready, go to IDLE. o_valid drops the next cycle; o_result and flags hold their last value until the next completion.
- Latency: the request accepted at edge T gives o_valid=1 after edge T+NUM_BYTES (4 cycles for WIDTH=32).
- Throughput: one operation per NUM_BYTES+2 cycles minimum. No back-to-back acceptance: o_ready is high only in IDLE.
- Inputs i_a, i_b and i_sub are ignored unless i_valid&o_ready. Changes to them during RUN or DONE have no effect.
- Backpressure: DONE is held indefinitely while i_ready=0.
- Reset asserted in any state (including mid-RUN) returns to reset values on that edge. The partial result is discarded and no o_valid pulse is produced.
- The i_valid/o_ready and o_valid/i_ready handshakes never occur in the same cycle, because o_ready=0 in DONE.
- All arithmetic wraps modulo 2^WIDTH. No X propagation on outputs after reset.

Test Plan:
- Add, A=0x000000FF, B=0x00000001, sub=0 -> after 4 cycles o_result=0x00000100, carry=0, overflow=0, zero=0, negative=0.
- Subtract, A=5, B=7, sub=1 -> o_result=0xFFFFFFFE, carry=0, ltu=1, lt=1, negative=1, overflow=0.
- Signed overflow:
  - A=0x7FFFFFFF + B=1 -> 0x80000000, overflow=1, negative=1.
  - A=0x80000000 - B=1 -> 0x7FFFFFFF, overflow=1, lt=1, ltu=0, carry=1.
- Equality, A=B=0x12345678, sub=1 -> o_result=0, zero=1, carry=1, lt=0, ltu=0. Also 0xFFFFFFFF+1 -> 0, carry=1, zero=1.
- Backpressure:
  - Hold i_ready=0 for 10 cycles after o_valid -> o_valid stays 1 and result/flags stay stable; o_ready stays 0 and i_valid pulses are ignored.
  - Release i_ready -> IDLE the next cycle, o_ready=1.
- Reset mid-op: deassert i_rst_n on cycle 2 of RUN -> next edge o_ready=1, o_valid=0, o_result=0, flags=0. The following request A=3, B=4, sub=0 completes with 7 after 4 cycles.
